// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// bubble word and word-alignment helpers.
package ifetch_stage_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READY = 2'd1,
    S_DROP  = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_STEP         = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifetch_stage_ifpc_reg.sv
// Program counter register: redirect beats hold, hold beats increment.
module ifpc_reg
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        advance,
  input  logic        hold,
  output logic [31:0] pc
);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= word_align(target);
    end else if (advance && !hold) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: issues word fetches, parks a held instruction in a
// one-entry buffer and swallows the response of a request orphaned by a redirect.
//
// Memory handshake: IMEMREQ/IMEMADDR are driven only from registered state, so
// once raised they stay constant until the cycle IMEMACK is seen (which may be
// the request cycle itself); IMEMRDATA is consumed only in that ACK cycle.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        PCHOLD,
  input  logic        BRANCHTAKEN,
  input  logic [31:0] BRANCHTARGET,
  input  logic        JUMP,
  input  logic [31:0] JUMPTARGET,
  output logic        IMEMREQ,
  output logic [31:0] IMEMADDR,
  input  logic        IMEMACK,
  input  logic [31:0] IMEMRDATA,
  output logic [31:0] TOIFIDPC4,
  output logic [31:0] TOIFIDORDER,
  output logic        FETCHVALID,
  output logic        IFFLASH,
  output if_state_e   DBGSTATE
);

  if_state_e   state, state_nxt;
  logic [31:0] pc;
  logic [31:0] buf_q;
  logic [31:0] stale_q;
  logic        redirect;
  logic [31:0] target;
  logic        advance;
  logic        buf_load;
  logic        stale_load;
  logic        req_c;
  logic        valid_c;
  logic [31:0] order_c;
  logic [31:0] addr_c;

  // Branch outranks jump when ID raises both.
  assign redirect = BRANCHTAKEN | JUMP;
  assign target   = BRANCHTAKEN ? BRANCHTARGET : JUMPTARGET;

  ifpc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .redirect (redirect),
    .target   (target),
    .advance  (advance),
    .hold     (PCHOLD),
    .pc       (pc)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_FETCH;
      buf_q   <= NOP_WORD;
      stale_q <= NOP_WORD;
    end else begin
      state <= state_nxt;
      if (buf_load)   buf_q   <= IMEMRDATA;
      if (stale_load) stale_q <= pc;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_c      = 1'b0;
    addr_c     = pc;
    valid_c    = 1'b0;
    order_c    = NOP_WORD;
    advance    = 1'b0;
    buf_load   = 1'b0;
    stale_load = 1'b0;
    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (IMEMACK) begin
          advance = 1'b1;
          if (!redirect) begin
            valid_c = 1'b1;
            order_c = IMEMRDATA;
            if (PCHOLD) begin
              buf_load  = 1'b1;
              state_nxt = S_READY;
            end
          end
        end else if (redirect) begin
          // The old request is still owed a response; remember where it went.
          stale_load = 1'b1;
          state_nxt  = S_DROP;
        end
      end
      S_READY: begin
        advance = 1'b1;
        if (!redirect) begin
          valid_c = 1'b1;
          order_c = buf_q;
        end
        if (redirect || !PCHOLD) state_nxt = S_FETCH;
      end
      S_DROP: begin
        req_c  = 1'b1;
        addr_c = stale_q;
        if (IMEMACK) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset gates the handshake outputs immediately, not at the next edge.
  assign IMEMREQ     = RESET & req_c;
  assign IMEMADDR    = addr_c;
  assign FETCHVALID  = RESET & valid_c;
  assign TOIFIDORDER = FETCHVALID ? order_c : NOP_WORD;
  assign TOIFIDPC4   = pc + PC_STEP;
  assign IFFLASH     = RESET & (redirect | (~FETCHVALID & ~PCHOLD));
  assign DBGSTATE    = state;

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port CLOCK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port PCHOLD  in  1  hazard-unit hold; 1 = hold PC and fetched instruction.
REQ-005 SHALL have port BRANCHTAKEN  in  1  branch resolved taken in ID.
REQ-006 SHALL have port BRANCHTARGET  in  32  branch target address.
REQ-007 SHALL have port JUMP  in  1  jump decoded in ID.
REQ-008 SHALL have port JUMPTARGET  in  32  jump target address.
REQ-009 SHALL have port IMEMREQ  out  1  instruction-memory request.
REQ-010 SHALL have port IMEMADDR  out  32  instruction-memory word address.
REQ-011 SHALL have port IMEMACK  in  1  memory response valid; IMEMRDATA valid same cycle.
REQ-012 SHALL have port IMEMRDATA  in  32  fetched instruction word.
REQ-013 SHALL have port TOIFIDPC4  out  32  PC+4 of presented instruction, to IF/ID.
REQ-014 SHALL have port TOIFIDORDER  out  32  presented instruction, to IF/ID.
REQ-015 SHALL have port FETCHVALID  out  1  TOIFIDORDER holds a valid instruction this cycle.
REQ-016 SHALL have port IFFLASH  out  1  flush request to IF/ID (load bubble 0).

Function
REQ-017 SHALL implement three states: FETCH, READY, DROP; reset state FETCH.
REQ-018 Memory protocol: once IMEMREQ=1, IMEMREQ and IMEMADDR SHALL stay constant until the IMEMACK cycle; ACK may arrive in the request cycle (zero wait).
REQ-019 FETCH: IMEMREQ=1, IMEMADDR=PC; on IMEMACK, TOIFIDORDER=IMEMRDATA, FETCHVALID=1.
REQ-020 FETCH, IMEMACK=1, PCHOLD=0, no redirect: PC<=PC+4, stay FETCH (one instruction per cycle at zero wait).
REQ-021 FETCH, IMEMACK=1, PCHOLD=1, no redirect: IMEMRDATA SHALL be captured in a one-entry buffer, go READY; PC unchanged.
REQ-022 READY: IMEMREQ=0, TOIFIDORDER=buffer, FETCHVALID=1; on PCHOLD=0 PC<=PC+4, go FETCH.
REQ-023 Redirect = BRANCHTAKEN|JUMP; BRANCHTAKEN SHALL win if both asserted; target low 2 bits SHALL be forced to 0.
REQ-024 Redirect SHALL take priority over PCHOLD: PC<=target, IFFLASH=1, FETCHVALID=0 that cycle.
REQ-025 Redirect in FETCH with IMEMACK=0: in-flight address SHALL be saved to a stale-address register, go DROP.
REQ-026 Redirect in FETCH with IMEMACK=1, or in READY: response/buffer discarded, go FETCH.
REQ-027 DROP: IMEMREQ=1, IMEMADDR=stale address, FETCHVALID=0; on IMEMACK data discarded, go FETCH; redirect in DROP updates PC only.
REQ-028 IFFLASH SHALL equal redirect | (~FETCHVALID & ~PCHOLD).
REQ-029 TOIFIDPC4 SHALL equal PC+4 (32-bit, wrap 32'hFFFF_FFFC+4 -> 0) whenever FETCHVALID=1; TOIFIDORDER SHALL be 0 when FETCHVALID=0.

Reset
REQ-030 While RESET=0: PC=RESET_PC, state FETCH, buffer and stale address 0, IMEMREQ=0, FETCHVALID=0, IFFLASH=0, TOIFIDORDER=0.
REQ-031 Reset during an outstanding request SHALL abandon it; first request after release SHALL use RESET_PC.

Structure
REQ-032 Shared package SHALL hold state encoding, NOP word 32'h0, and word-align mask.
REQ-033 PC register with hold/redirect/increment SHALL be sub-module ifpc_reg; FSM, buffer and stale address stay in ifetch_stage.

Verification
REQ-034 Zero-wait ACK, RESET_PC=0x100, no hold -> TOIFIDPC4 = 0x104, 0x108, 0x10C on consecutive cycles, FETCHVALID=1.
REQ-035 ACK at PC 0x200 with PCHOLD=1 for 3 cycles -> READY, TOIFIDORDER stable, IMEMREQ=0; release -> next IMEMADDR 0x204.
REQ-036 Request 0x300 pending (ACK delayed 2 cycles), JUMP to 0x403 -> IFFLASH=1, DROP keeps IMEMADDR 0x300, stale data discarded, next IMEMADDR 0x400.
REQ-037 BRANCHTAKEN (0x500) and JUMP (0x600) same cycle with PCHOLD=1 -> PC=0x500, IFFLASH=1.
REQ-038 RESET low mid-request at 0x700 -> IMEMREQ=0 immediately; after release IMEMADDR=RESET_PC.
REQ-039 PC=0xFFFF_FFFC, ACK -> TOIFIDPC4=0x0000_0000, next IMEMADDR 0x0.
